// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Brief   : Shared stall-bus encodings and MDU sequencer state codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int MDU_CNT_W = 6;

  typedef logic [5:0] stall_bus_t;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  // Highest-priority source wins; the result is always a run of ones from bit 0.
  function automatic stall_bus_t encode_stall(input logic mem, input logic ex,
                                              input logic id);
    stall_bus_t v;
    v = STALL_NONE;
    if (mem)     v = STALL_MEM;
    else if (ex) v = STALL_EX;
    else if (id) v = STALL_ID;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_mdu_seq.sv
// ============================================================================
// Module  : mdu_seq
// Brief   : Multi-cycle MDU sequencer: holds EX for a programmed cycle count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mdu_start,
  input  logic [CNT_W-1:0] mdu_cycles,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  output logic             mdu_stall,
  output logic             mdu_busy,
  output logic             mdu_done
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             start_acc;

  assign start_acc = (state == MDU_IDLE) && mdu_start;
  assign mdu_stall = (state == MDU_BUSY) || start_acc;
  assign mdu_busy  = mdu_stall;
  assign mdu_done  = (state == MDU_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (mdu_start) begin
            // Start cycle is stalled cycle 1; a count of 0 behaves like 1.
            if (mdu_cycles <= CNT_W'(1)) begin
              state <= MDU_DONE;
              cnt   <= '0;
            end else begin
              state <= MDU_BUSY;
              cnt   <= mdu_cycles - CNT_W'(1);
            end
          end
        end
        MDU_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MDU_DONE;
        end
        MDU_DONE: begin
          // EX cannot retire the result while either later stall holds it.
          if (!stallreq_mem && !stallreq_ex) state <= MDU_IDLE;
        end
        default: begin
          state <= MDU_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Brief   : Pipeline stall priority encoder, MDU sequencing and stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = MDU_CNT_W,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              mdu_start,
  input  logic [CNT_W-1:0]  mdu_cycles,
  output logic [5:0]        stall,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cycles
);

  logic mdu_stall;

  mdu_seq #(
    .CNT_W (CNT_W)
  ) u_mdu_seq (
    .clk          (clk),
    .rst          (rst),
    .mdu_start    (mdu_start),
    .mdu_cycles   (mdu_cycles),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .mdu_stall    (mdu_stall),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done)
  );

  always_comb begin
    stall = encode_stall(stallreq_mem, stallreq_ex || mdu_stall, stallreq_id);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((stall != STALL_NONE) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule

`default_nettype wire
